// File: rtl/dma_rd_scheduler.sv
// dma_rd_scheduler: splits one host-to-FPGA DMA read into memory-read
// requests, allocates a tag per request and retires tags as completion
// data arrives; pulses done once every tag has drained.
module dma_rd_scheduler #(
    parameter int MAX_RD_DW = 128,
    parameter int NUM_TAGS  = 8
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        dma_start_i,
    input  logic [31:0] dma_src_addr_i,
    input  logic [31:0] dma_len_i,
    output logic        dma_busy_o,
    output logic        dma_done_o,
    output logic        dma_err_o,
    output logic        rd_req_o,
    output logic [31:0] rd_req_addr_o,
    output logic [9:0]  rd_req_len_o,
    output logic [7:0]  rd_req_tag_o,
    input  logic        rd_req_ack_i,
    input  logic        cpld_start_i,
    input  logic [7:0]  cpld_tag_i,
    input  logic        rcvd_data_valid_i
);
    localparam int          TW    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [12:0] MAX_B = 13'(MAX_RD_DW * 4);
    localparam logic [8:0]  NT9   = 9'(NUM_TAGS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, DONE} state_t;

    state_t                       state;
    logic [31:0]                  cur_addr;
    logic [31:0]                  rem_bytes;
    logic [12:0]                  req_bytes;
    logic [NUM_TAGS-1:0]          outst;
    logic [NUM_TAGS-1:0][9:0]     rdw;
    logic [TW-1:0]                cur_idx;
    logic                         cur_ok;

    logic [TW-1:0]                free_idx;
    logic                         free_any;
    logic [12:0]                  to_bnd, c1, chunk;
    logic                         new_ok, eff_ok, beat_ok;
    logic [TW-1:0]                eff_idx, ack_idx;
    logic [9:0]                   dw_left;

    // Lowest-numbered free tag from the registered outstanding mask
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!outst[i]) begin
                free_idx = TW'(i);
                free_any = 1'b1;
            end
        end
    end

    // Chunk size: min(max request, remaining bytes, distance to 4 KB boundary);
    // completion tag resolution where a same-cycle header overrides cur_tag
    always_comb begin
        to_bnd  = 13'd4096 - {1'b0, cur_addr[11:0]};
        c1      = (MAX_B < to_bnd) ? MAX_B : to_bnd;
        chunk   = (rem_bytes < {19'b0, c1}) ? rem_bytes[12:0] : c1;
        new_ok  = ({1'b0, cpld_tag_i} < NT9) && outst[cpld_tag_i[TW-1:0]];
        eff_idx = cpld_start_i ? cpld_tag_i[TW-1:0] : cur_idx;
        eff_ok  = cpld_start_i ? new_ok : cur_ok;
        beat_ok = rcvd_data_valid_i && eff_ok && outst[eff_idx];
        dw_left = rdw[eff_idx] - 10'd2;
        ack_idx = rd_req_tag_o[TW-1:0];
    end

    // Request FSM plus completion tracking; a free and an allocation in the
    // same cycle touch different tags so both land
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= '0;
            rem_bytes     <= '0;
            req_bytes     <= '0;
            outst         <= '0;
            rdw           <= '0;
            cur_idx       <= '0;
            cur_ok        <= 1'b0;
            dma_busy_o    <= 1'b0;
            dma_done_o    <= 1'b0;
            dma_err_o     <= 1'b0;
            rd_req_o      <= 1'b0;
            rd_req_addr_o <= '0;
            rd_req_len_o  <= '0;
            rd_req_tag_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dma_done_o <= 1'b0;
                    if (dma_start_i) begin
                        cur_addr   <= dma_src_addr_i;
                        rem_bytes  <= dma_len_i;
                        dma_err_o  <= 1'b0;
                        dma_busy_o <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rem_bytes == 32'd0) begin
                        state <= DRAIN;
                    end else if (free_any) begin
                        rd_req_o      <= 1'b1;
                        rd_req_addr_o <= cur_addr;
                        rd_req_len_o  <= chunk[11:2];
                        rd_req_tag_o  <= 8'(free_idx);
                        req_bytes     <= chunk;
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (rd_req_ack_i) begin
                        rd_req_o     <= 1'b0;
                        outst[ack_idx] <= 1'b1;
                        rdw[ack_idx] <= rd_req_len_o;
                        cur_addr     <= cur_addr + {19'b0, req_bytes};
                        rem_bytes    <= rem_bytes - {19'b0, req_bytes};
                        state        <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (outst == '0) begin
                        dma_done_o <= 1'b1;
                        dma_busy_o <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    dma_done_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Header for a tag that is not outstanding flags an error and
            // makes its data beats inert
            if (cpld_start_i) begin
                cur_idx <= cpld_tag_i[TW-1:0];
                cur_ok  <= new_ok;
                if (!new_ok) dma_err_o <= 1'b1;
            end
            if (beat_ok) begin
                rdw[eff_idx] <= dw_left;
                if (dw_left == 10'd0) begin
                    outst[eff_idx] <= 1'b0;
                    cur_ok         <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_rd_scheduler.sv
// Directed bench for dma_rd_scheduler: single/multi-chunk, 4 KB split,
// tag exhaustion, split completions, error flag and mid-transfer reset.
module tb_dma_rd_scheduler;
    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        dma_start_i;
    logic [31:0] dma_src_addr_i;
    logic [31:0] dma_len_i;
    logic        dma_busy_o, dma_done_o, dma_err_o;
    logic        rd_req_o;
    logic [31:0] rd_req_addr_o;
    logic [9:0]  rd_req_len_o;
    logic [7:0]  rd_req_tag_o;
    logic        rd_req_ack_i;
    logic        cpld_start_i;
    logic [7:0]  cpld_tag_i;
    logic        rcvd_data_valid_i;

    int n_chk = 0;
    int n_err = 0;

    dma_rd_scheduler #(.MAX_RD_DW(128), .NUM_TAGS(8)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .dma_start_i(dma_start_i), .dma_src_addr_i(dma_src_addr_i),
        .dma_len_i(dma_len_i), .dma_busy_o(dma_busy_o),
        .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
        .rd_req_o(rd_req_o), .rd_req_addr_o(rd_req_addr_o),
        .rd_req_len_o(rd_req_len_o), .rd_req_tag_o(rd_req_tag_o),
        .rd_req_ack_i(rd_req_ack_i), .cpld_start_i(cpld_start_i),
        .cpld_tag_i(cpld_tag_i), .rcvd_data_valid_i(rcvd_data_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_start(input logic [31:0] addr, input logic [31:0] len);
        dma_start_i    = 1'b1;
        dma_src_addr_i = addr;
        dma_len_i      = len;
        tick();
        dma_start_i    = 1'b0;
    endtask

    task automatic expect_req(input string nm, input logic [31:0] addr,
                              input logic [31:0] len, input logic [31:0] tag,
                              input int ack_dly);
        int n = 0;
        while (!rd_req_o && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_req"}, 32'(rd_req_o), 1);
        chk({nm, "_addr"}, rd_req_addr_o, addr);
        chk({nm, "_len"}, 32'(rd_req_len_o), len);
        chk({nm, "_tag"}, 32'(rd_req_tag_o), tag);
        if (ack_dly > 0) begin
            repeat (ack_dly) tick();
            chk({nm, "_hold_req"}, 32'(rd_req_o), 1);
            chk({nm, "_hold_addr"}, rd_req_addr_o, addr);
        end
        rd_req_ack_i = 1'b1;
        tick();
        rd_req_ack_i = 1'b0;
        chk({nm, "_drop"}, 32'(rd_req_o), 0);
    endtask

    // Header and first beat share a cycle
    task automatic send_cpl(input logic [7:0] tag, input int beats);
        cpld_start_i      = 1'b1;
        cpld_tag_i        = tag;
        rcvd_data_valid_i = 1'b1;
        tick();
        cpld_start_i = 1'b0;
        repeat (beats - 1) tick();
        rcvd_data_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!dma_done_o && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, 32'(dma_done_o), 1);
        chk({nm, "_busy_low"}, 32'(dma_busy_o), 0);
        tick();
        chk({nm, "_done_pulse"}, 32'(dma_done_o), 0);
    endtask

    task automatic no_req_for(input string nm, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            tick();
            if (rd_req_o) seen++;
        end
        chk(nm, 32'(seen), 0);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; dma_start_i = 1'b0; dma_src_addr_i = '0; dma_len_i = '0;
        rd_req_ack_i = 1'b0; cpld_start_i = 1'b0; cpld_tag_i = '0;
        rcvd_data_valid_i = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(dma_busy_o), 0);
        chk("rst_done", 32'(dma_done_o), 0);
        chk("rst_err", 32'(dma_err_o), 0);
        chk("rst_req", 32'(rd_req_o), 0);
        chk("rst_fields", {rd_req_addr_o[21:0], rd_req_len_o} | 32'(rd_req_tag_o), 0);
        rst_n = 1'b1;
        tick();

        // Single chunk with exact latencies
        do_start(32'h1000_0000, 64);
        chk("s1_busy", 32'(dma_busy_o), 1);
        chk("s1_req_lat1", 32'(rd_req_o), 0);
        tick();
        chk("s1_req_lat2", 32'(rd_req_o), 1);
        expect_req("s1", 32'h1000_0000, 16, 0, 0);
        send_cpl(8'd0, 8);
        chk("s1_done_lat1", 32'(dma_done_o), 0);
        tick();
        chk("s1_done_lat2", 32'(dma_done_o), 1);
        chk("s1_busy_low", 32'(dma_busy_o), 0);
        tick();
        chk("s1_done_pulse", 32'(dma_done_o), 0);

        // Multi-chunk, completions out of order
        do_start(32'h0, 1024);
        expect_req("m0", 32'h0, 128, 0, 0);
        expect_req("m1", 32'h200, 128, 1, 0);
        send_cpl(8'd1, 64);
        chk("m_not_done", 32'(dma_done_o), 0);
        send_cpl(8'd0, 64);
        wait_done("m");

        // 4 KB boundary split, ack held off to check stability
        do_start(32'h0000_0FF0, 64);
        expect_req("b0", 32'hFF0, 4, 0, 2);
        expect_req("b1", 32'h1000, 12, 1, 2);
        send_cpl(8'd0, 2);
        send_cpl(8'd1, 6);
        wait_done("b");

        // Tag exhaustion
        do_start(32'h0, 8192);
        for (int i = 0; i < 8; i++)
            expect_req($sformatf("x%0d", i), 32'(i * 32'h200), 128, 32'(i), 0);
        no_req_for("x_stall", 10);
        do_start(32'h5000, 64);           // ignored while busy
        chk("x_busy", 32'(dma_busy_o), 1);
        send_cpl(8'd3, 64);
        expect_req("x8", 32'h1000, 128, 3, 0);

        // Split completion on tag 0: freed only after the 64th beat
        send_cpl(8'd0, 32);
        no_req_for("sp_half", 5);
        send_cpl(8'd0, 32);
        expect_req("sp", 32'h1200, 128, 0, 0);

        // Reset mid-transfer
        rst_n = 1'b0;
        tick();
        chk("mr_busy", 32'(dma_busy_o), 0);
        chk("mr_req", 32'(rd_req_o), 0);
        chk("mr_addr", rd_req_addr_o, 0);
        chk("mr_lentag", {rd_req_len_o, rd_req_tag_o}, 0);
        chk("mr_err", 32'(dma_err_o), 0);
        tick();
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            tick();
            if (dma_done_o || dma_busy_o || rd_req_o) dn++;
        end
        chk("mr_quiet", 32'(dn), 0);

        // Bad completion tag sets sticky error and leaves tag 0 intact
        do_start(32'h2000, 64);
        expect_req("e0", 32'h2000, 16, 0, 0);
        send_cpl(8'd5, 2);
        chk("e_err", 32'(dma_err_o), 1);
        send_cpl(8'd0, 8);
        wait_done("e");
        chk("e_err_sticky", 32'(dma_err_o), 1);
        do_start(32'h3000, 8);
        chk("e_err_clr", 32'(dma_err_o), 0);
        expect_req("e1", 32'h3000, 2, 0, 0);
        send_cpl(8'd0, 1);
        wait_done("e1");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
